// File: rtl/axi4l_cmd_master_if.sv
// Signal bundle for the AXI4-Lite command master: command/response side
// plus the AXI4-Lite master bus. master = the block, slave = its surroundings.
interface axi4l_cmd_master_if #(
    parameter int AXI4L_ADDR_BITS = 40,
    parameter int AXI4L_DATA_BITS = 64
);
    localparam int STRB_BITS = AXI4L_DATA_BITS / 8;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AXI4L_ADDR_BITS-1:0] cmd_addr;
    logic [AXI4L_DATA_BITS-1:0] cmd_wdata;
    logic [STRB_BITS-1:0]       cmd_wstrb;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [AXI4L_DATA_BITS-1:0] rsp_rdata;
    logic [1:0]                 rsp_resp;

    logic [AXI4L_ADDR_BITS-1:0] m_axi4l_awaddr;
    logic [2:0]                 m_axi4l_awprot;
    logic                       m_axi4l_awvalid;
    logic                       m_axi4l_awready;
    logic [AXI4L_DATA_BITS-1:0] m_axi4l_wdata;
    logic [STRB_BITS-1:0]       m_axi4l_wstrb;
    logic                       m_axi4l_wvalid;
    logic                       m_axi4l_wready;
    logic [1:0]                 m_axi4l_bresp;
    logic                       m_axi4l_bvalid;
    logic                       m_axi4l_bready;
    logic [AXI4L_ADDR_BITS-1:0] m_axi4l_araddr;
    logic [2:0]                 m_axi4l_arprot;
    logic                       m_axi4l_arvalid;
    logic                       m_axi4l_arready;
    logic [AXI4L_DATA_BITS-1:0] m_axi4l_rdata;
    logic [1:0]                 m_axi4l_rresp;
    logic                       m_axi4l_rvalid;
    logic                       m_axi4l_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output m_axi4l_awaddr, m_axi4l_awprot, m_axi4l_awvalid,
        input  m_axi4l_awready,
        output m_axi4l_wdata, m_axi4l_wstrb, m_axi4l_wvalid,
        input  m_axi4l_wready,
        input  m_axi4l_bresp, m_axi4l_bvalid,
        output m_axi4l_bready,
        output m_axi4l_araddr, m_axi4l_arprot, m_axi4l_arvalid,
        input  m_axi4l_arready,
        input  m_axi4l_rdata, m_axi4l_rresp, m_axi4l_rvalid,
        output m_axi4l_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  m_axi4l_awaddr, m_axi4l_awprot, m_axi4l_awvalid,
        output m_axi4l_awready,
        input  m_axi4l_wdata, m_axi4l_wstrb, m_axi4l_wvalid,
        output m_axi4l_wready,
        output m_axi4l_bresp, m_axi4l_bvalid,
        input  m_axi4l_bready,
        input  m_axi4l_araddr, m_axi4l_arprot, m_axi4l_arvalid,
        output m_axi4l_arready,
        output m_axi4l_rdata, m_axi4l_rresp, m_axi4l_rvalid,
        input  m_axi4l_rready
    );
endinterface

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one
// AXI4-Lite read or write and returns the captured response.
module axi4l_cmd_master #(
    parameter int AXI4L_ADDR_BITS = 40,
    parameter int AXI4L_DATA_BITS = 64
) (
    input  logic                m_axi4l_aclk,
    input  logic                m_axi4l_aresetn,
    axi4l_cmd_master_if.master  bus
);
    localparam int AW = AXI4L_ADDR_BITS;
    localparam int DW = AXI4L_DATA_BITS;
    localparam int SW = AXI4L_DATA_BITS / 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_BRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;
    logic          aw_done, w_done;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = ~awvalid_q | bus.m_axi4l_awready;
    assign w_done  = ~wvalid_q  | bus.m_axi4l_wready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    wstrb_d     = bus.cmd_wstrb;
                    if (bus.cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WRITE: begin
                if (awvalid_q && bus.m_axi4l_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.m_axi4l_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_BRESP;
                end
            end
            S_BRESP: begin
                if (bus.m_axi4l_bvalid) begin
                    bready_d    = 1'b0;
                    resp_d      = bus.m_axi4l_bresp;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RADDR: begin
                if (bus.m_axi4l_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (bus.m_axi4l_rvalid) begin
                    rready_d    = 1'b0;
                    resp_d      = bus.m_axi4l_rresp;
                    rdata_d     = bus.m_axi4l_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi4l_aclk or negedge m_axi4l_aresetn) begin
        if (!m_axi4l_aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_resp        = resp_q;
    assign bus.m_axi4l_awaddr  = addr_q;
    assign bus.m_axi4l_awprot  = 3'b000;
    assign bus.m_axi4l_awvalid = awvalid_q;
    assign bus.m_axi4l_wdata   = wdata_q;
    assign bus.m_axi4l_wstrb   = wstrb_q;
    assign bus.m_axi4l_wvalid  = wvalid_q;
    assign bus.m_axi4l_bready  = bready_q;
    assign bus.m_axi4l_araddr  = addr_q;
    assign bus.m_axi4l_arprot  = 3'b000;
    assign bus.m_axi4l_arvalid = arvalid_q;
    assign bus.m_axi4l_rready  = rready_q;
endmodule

// File: tb/tb_axi4l_cmd_master.sv
// Bench for axi4l_cmd_master: memory-backed AXI4-Lite slave with
// configurable stalls, reference memory model and response scoreboard.
module tb_axi4l_cmd_master;
    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  r;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [63:0] rmem [logic [39:0]];
    logic [63:0] smem [logic [39:0]];
    int   aw_k, w_k, ar_k, b_k, r_k, rs_k;
    int   kgen = 0;

    axi4l_cmd_master_if #(.AXI4L_ADDR_BITS(40), .AXI4L_DATA_BITS(64)) bus ();

    axi4l_cmd_master dut (
        .m_axi4l_aclk   (clk),
        .m_axi4l_aresetn(rst_n),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] resp_of(logic [39:0] a);
        case (a[7:4])
            4'hF:    return 2'b10;
            4'hE:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [63:0] init_val(logic [39:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic int pick(int k);
        return (k >= 0) ? k : int'($urandom_range(0, 3));
    endfunction

    // Reference: a command's response is fully determined by memory contents.
    function automatic void model_push(bit w, logic [39:0] a,
                                       logic [63:0] d, logic [7:0] s);
        exp_t e;
        logic [63:0] cur;
        cur = rmem.exists(a) ? rmem[a] : init_val(a);
        if (w) begin
            for (int i = 0; i < 8; i++)
                if (s[i]) cur[i*8 +: 8] = d[i*8 +: 8];
            rmem[a] = cur;
            e.d = 64'h0;
        end else begin
            e.d = cur;
        end
        e.r = resp_of(a);
        sb.push_back(e);
    endfunction

    task automatic set_knobs(int aw, int w, int ar, int b, int r, int rs);
        aw_k = aw; w_k = w; ar_k = ar; b_k = b; r_k = r; rs_k = rs;
        kgen++;
    endtask

    // Slave + response consumer, all driven on the falling edge.
    initial begin : env
        int aw_c, w_c, ar_c, b_c, r_c, rs_c, seen;
        logic aw_s, w_s, ar_s, b_f, r_f;
        logic [39:0] aw_a, ar_a;
        logic [63:0] w_d, cur;
        logic [7:0]  w_b;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; rs_c = 0; seen = -1;
        aw_s = 0; w_s = 0; ar_s = 0; b_f = 0; r_f = 0;
        aw_a = '0; ar_a = '0; w_d = '0; w_b = '0;
        bus.m_axi4l_awready = 0; bus.m_axi4l_wready = 0;
        bus.m_axi4l_bvalid = 0; bus.m_axi4l_bresp = 0;
        bus.m_axi4l_arready = 0; bus.m_axi4l_rvalid = 0;
        bus.m_axi4l_rdata = 0; bus.m_axi4l_rresp = 0; bus.rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_s = 0; w_s = 0; ar_s = 0; b_f = 0; r_f = 0; seen = -1;
                bus.m_axi4l_awready = 0; bus.m_axi4l_wready = 0;
                bus.m_axi4l_bvalid = 0; bus.m_axi4l_arready = 0;
                bus.m_axi4l_rvalid = 0; bus.rsp_ready = 0;
            end else begin
                if (seen != kgen) begin
                    seen = kgen;
                    aw_c = pick(aw_k); w_c = pick(w_k); ar_c = pick(ar_k);
                    b_c = pick(b_k); r_c = pick(r_k); rs_c = pick(rs_k);
                end
                if (b_f) begin bus.m_axi4l_bvalid = 0; b_f = 0; end
                if (r_f) begin bus.m_axi4l_rvalid = 0; r_f = 0; end
                if (aw_s && w_s) begin
                    if (b_c == 0) begin
                        cur = smem.exists(aw_a) ? smem[aw_a] : init_val(aw_a);
                        for (int i = 0; i < 8; i++)
                            if (w_b[i]) cur[i*8 +: 8] = w_d[i*8 +: 8];
                        smem[aw_a] = cur;
                        bus.m_axi4l_bvalid = 1;
                        bus.m_axi4l_bresp = resp_of(aw_a);
                        aw_s = 0; w_s = 0;
                    end else b_c--;
                end
                if (ar_s) begin
                    if (r_c == 0) begin
                        bus.m_axi4l_rvalid = 1;
                        bus.m_axi4l_rdata =
                            smem.exists(ar_a) ? smem[ar_a] : init_val(ar_a);
                        bus.m_axi4l_rresp = resp_of(ar_a);
                        ar_s = 0;
                    end else r_c--;
                end
                if (bus.m_axi4l_awvalid && !aw_s) begin
                    bus.m_axi4l_awready = (aw_c == 0);
                    if (aw_c > 0) aw_c--;
                end else bus.m_axi4l_awready = 0;
                if (bus.m_axi4l_wvalid && !w_s) begin
                    bus.m_axi4l_wready = (w_c == 0);
                    if (w_c > 0) w_c--;
                end else bus.m_axi4l_wready = 0;
                if (bus.m_axi4l_arvalid && !ar_s) begin
                    bus.m_axi4l_arready = (ar_c == 0);
                    if (ar_c > 0) ar_c--;
                end else bus.m_axi4l_arready = 0;
                if (bus.m_axi4l_awvalid && bus.m_axi4l_awready) begin
                    aw_s = 1; aw_a = bus.m_axi4l_awaddr; aw_c = pick(aw_k);
                    if (w_s) b_c = pick(b_k);
                end
                if (bus.m_axi4l_wvalid && bus.m_axi4l_wready) begin
                    w_s = 1; w_d = bus.m_axi4l_wdata; w_b = bus.m_axi4l_wstrb;
                    w_c = pick(w_k);
                    if (aw_s) b_c = pick(b_k);
                end
                if (bus.m_axi4l_arvalid && bus.m_axi4l_arready) begin
                    ar_s = 1; ar_a = bus.m_axi4l_araddr; ar_c = pick(ar_k);
                end
                b_f = bus.m_axi4l_bvalid && bus.m_axi4l_bready;
                r_f = bus.m_axi4l_rvalid && bus.m_axi4l_rready;
                if (bus.rsp_valid) begin
                    bus.rsp_ready = (rs_c == 0);
                    if (rs_c > 0) rs_c--;
                    if (bus.rsp_ready) rs_c = pick(rs_k);
                end else bus.rsp_ready = 0;
            end
        end
    end

    // Monitor: scoreboard pops on response handshake; stalls must hold payloads.
    initial begin : mon
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rsv, p_rsr;
        logic [39:0] p_awa, p_ara;
        logic [63:0] p_wd, p_rd;
        logic [7:0]  p_ws;
        logic [1:0]  p_rr;
        exp_t e;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_arv = 0; p_arr = 0; p_rsv = 0; p_rsr = 0;
        p_awa = 0; p_ara = 0; p_wd = 0; p_rd = 0; p_ws = 0; p_rr = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                sb.delete();
                p_awv = 0; p_wv = 0; p_arv = 0; p_rsv = 0;
            end else begin
                if (p_awv && !p_awr) begin
                    chk("awvalid_hold", 64'(bus.m_axi4l_awvalid), 64'd1);
                    chk("awaddr_stable", 64'(bus.m_axi4l_awaddr), 64'(p_awa));
                end
                if (p_wv && !p_wr) begin
                    chk("wvalid_hold", 64'(bus.m_axi4l_wvalid), 64'd1);
                    chk("wdata_stable", bus.m_axi4l_wdata, p_wd);
                    chk("wstrb_stable", 64'(bus.m_axi4l_wstrb), 64'(p_ws));
                end
                if (p_arv && !p_arr) begin
                    chk("arvalid_hold", 64'(bus.m_axi4l_arvalid), 64'd1);
                    chk("araddr_stable", 64'(bus.m_axi4l_araddr), 64'(p_ara));
                end
                if (p_rsv && !p_rsr) begin
                    chk("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
                    chk("rsp_rdata_stable", bus.rsp_rdata, p_rd);
                    chk("rsp_resp_stable", 64'(bus.rsp_resp), 64'(p_rr));
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, e.d);
                        chk("rsp_resp", 64'(bus.rsp_resp), 64'(e.r));
                    end
                end
                p_awv = bus.m_axi4l_awvalid; p_awr = bus.m_axi4l_awready;
                p_awa = bus.m_axi4l_awaddr;
                p_wv = bus.m_axi4l_wvalid; p_wr = bus.m_axi4l_wready;
                p_wd = bus.m_axi4l_wdata; p_ws = bus.m_axi4l_wstrb;
                p_arv = bus.m_axi4l_arvalid; p_arr = bus.m_axi4l_arready;
                p_ara = bus.m_axi4l_araddr;
                p_rsv = bus.rsp_valid; p_rsr = bus.rsp_ready;
                p_rd = bus.rsp_rdata; p_rr = bus.rsp_resp;
            end
        end
    end

    task automatic do_cmd(bit w, logic [39:0] a, logic [63:0] d, logic [7:0] s);
        int n = 0;
        bus.cmd_valid = 1; bus.cmd_write = w;
        bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s;
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        model_push(w, a, d, s);
        @(negedge clk);
        bus.cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [39:0] a;
        bus.cmd_valid = 0; bus.cmd_write = 0;
        bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
        set_knobs(0, 0, 0, 0, 0, 0);
        rmem[40'h20] = 64'hDEADBEEF;
        smem[40'h20] = 64'hDEADBEEF;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_valids", 64'({bus.m_axi4l_awvalid, bus.m_axi4l_wvalid,
            bus.m_axi4l_arvalid, bus.rsp_valid}), 64'd0);
        chk("rst_readys", 64'({bus.m_axi4l_bready, bus.m_axi4l_rready}), 64'd0);
        chk("rst_awaddr", 64'(bus.m_axi4l_awaddr), 64'd0);
        chk("rst_wdata", bus.m_axi4l_wdata, 64'd0);
        chk("rst_rsp", {bus.rsp_rdata[61:0], bus.rsp_resp}, 64'd0);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait write: aw/w at T+1, bvalid at T+2, rsp_valid at T+3
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 40'h10;
        bus.cmd_wdata = 64'h1122334455667788; bus.cmd_wstrb = 8'hFF;
        chk("w0_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        model_push(1, 40'h10, 64'h1122334455667788, 8'hFF);
        @(negedge clk);
        bus.cmd_valid = 0;
        #2;
        chk("w0_awwvalid_T1", 64'({bus.m_axi4l_awvalid, bus.m_axi4l_wvalid}), 64'd3);
        chk("w0_awaddr", 64'(bus.m_axi4l_awaddr), 64'h10);
        chk("w0_wdata", bus.m_axi4l_wdata, 64'h1122334455667788);
        chk("w0_wstrb", 64'(bus.m_axi4l_wstrb), 64'hFF);
        chk("w0_awprot", 64'(bus.m_axi4l_awprot), 64'd0);
        chk("w0_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        #2;
        chk("w0_b_T2", 64'({bus.m_axi4l_bvalid, bus.m_axi4l_bready,
            bus.m_axi4l_awvalid}), 64'd6);
        @(negedge clk);
        #2;
        chk("w0_rsp_valid_T3", 64'(bus.rsp_valid), 64'd1);
        drain();

        // Read 0x20 with one cycle of rvalid delay
        set_knobs(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        do_cmd(0, 40'h20, 64'h0, 8'h0);
        chk("r0_arprot", 64'(bus.m_axi4l_arprot), 64'd0);
        drain();

        // wready three cycles ahead of awready
        set_knobs(3, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 40'h40;
        bus.cmd_wdata = 64'hA1A2A3A4A5A6A7A8; bus.cmd_wstrb = 8'h0F;
        chk("w1_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        model_push(1, 40'h40, 64'hA1A2A3A4A5A6A7A8, 8'h0F);
        @(negedge clk);
        bus.cmd_valid = 0;
        #2;
        chk("w1_valids_T1", 64'({bus.m_axi4l_awvalid, bus.m_axi4l_wvalid}), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("w1_aw_held_w_done", 64'({bus.m_axi4l_awvalid,
                bus.m_axi4l_wvalid, bus.m_axi4l_bready}), 64'd4);
            chk("w1_awaddr", 64'(bus.m_axi4l_awaddr), 64'h40);
        end
        @(negedge clk);
        #2;
        chk("w1_bready_after_both", 64'({bus.m_axi4l_awvalid,
            bus.m_axi4l_bready}), 64'd1);
        drain();
        @(negedge clk);
        do_cmd(0, 40'h40, 64'h0, 8'h0);
        drain();

        // SLVERR read held by 4 cycles of rsp_ready low
        set_knobs(0, 0, 0, 0, 0, 4);
        @(negedge clk);
        @(negedge clk);
        do_cmd(0, 40'hF0, 64'h0, 8'h0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("r1_rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
            chk("r1_rsp_resp_slverr", 64'(bus.rsp_resp), 64'd2);
            chk("r1_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
            @(negedge clk);
        end
        drain();

        // Reset while awvalid waits for awready
        set_knobs(20, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 40'h300;
        bus.cmd_wdata = 64'h5555AAAA5555AAAA; bus.cmd_wstrb = 8'hFF;
        chk("w2_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        model_push(1, 40'h300, 64'h5555AAAA5555AAAA, 8'hFF);
        @(negedge clk);
        bus.cmd_valid = 0;
        repeat (2) @(negedge clk);
        #2;
        chk("w2_awvalid_waiting", 64'(bus.m_axi4l_awvalid), 64'd1);
        #1 rst_n = 0;
        #1;
        chk("w2_awvalid_async_clr", 64'(bus.m_axi4l_awvalid), 64'd0);
        chk("w2_regs_clr", 64'({bus.cmd_ready, bus.m_axi4l_bready,
            bus.m_axi4l_wvalid}), 64'd0);
        chk("w2_awaddr_clr", 64'(bus.m_axi4l_awaddr), 64'd0);
        set_knobs(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("w2_cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        do_cmd(0, 40'h20, 64'h0, 8'h0);
        drain();

        // Randomised traffic with random stalls everywhere
        set_knobs(-1, -1, -1, -1, -1, -1);
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            a = 40'hA5_0000_1000 + 40'($urandom_range(0, 15) * 16);
            do_cmd(1'($urandom_range(0, 1)), a, {$urandom(), $urandom()},
                   8'($urandom_range(0, 255)));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi4l_cmd_master.md
AXI4L_CMD_MASTER -- requirements
Module: axi4l_cmd_master

Interface
REQ-001 AXI4L_ADDR_BITS, 40, address width of command and AXI4-Lite address channels.
REQ-002 AXI4L_DATA_BITS, 64, data width; strobe width is AXI4L_DATA_BITS/8.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 m_axi4l_aclk  in  1  sole clock; all logic rising-edge.
REQ-005 m_axi4l_aresetn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when both high.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_BITS  target byte address.
REQ-010 cmd_wdata  in  DATA_BITS  write data (ignored for read).
REQ-011 cmd_wstrb  in  DATA_BITS/8  write strobes (ignored for read).
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when both high.
REQ-014 rsp_rdata  out  DATA_BITS  read data; 0 for writes.
REQ-015 rsp_resp  out  2  captured BRESP/RRESP.
REQ-016 m_axi4l_awaddr  out  ADDR_BITS  write address.
REQ-017 m_axi4l_awprot  out  3  constant 3'b000.
REQ-018 m_axi4l_awvalid  out  1  write address valid.
REQ-019 m_axi4l_awready  in  1  write address ready.
REQ-020 m_axi4l_wdata  out  DATA_BITS  write data.
REQ-021 m_axi4l_wstrb  out  DATA_BITS/8  write strobes.
REQ-022 m_axi4l_wvalid  out  1  write data valid.
REQ-023 m_axi4l_wready  in  1  write data ready.
REQ-024 m_axi4l_bresp  in  2  write response.
REQ-025 m_axi4l_bvalid  in  1  write response valid.
REQ-026 m_axi4l_bready  out  1  write response ready.
REQ-027 m_axi4l_araddr  out  ADDR_BITS  read address.
REQ-028 m_axi4l_arprot  out  3  constant 3'b000.
REQ-029 m_axi4l_arvalid  out  1  read address valid.
REQ-030 m_axi4l_arready  in  1  read address ready.
REQ-031 m_axi4l_rdata  in  DATA_BITS  read data.
REQ-032 m_axi4l_rresp  in  2  read response.
REQ-033 m_axi4l_rvalid  in  1  read data valid.
REQ-034 m_axi4l_rready  out  1  read data ready.

Function
REQ-035 FSM states IDLE, WRITE, BRESP, RADDR, RDATA, RSP; all outputs registered; exactly one transaction outstanding.
REQ-036 cmd_ready=1 only in IDLE; accept at edge T latches addr/wdata/wstrb; write -> WRITE with awvalid=wvalid=1 at T+1; read -> RADDR with arvalid=1 at T+1.
REQ-037 WRITE: awvalid held until awready, wvalid held until wready, independently; any order or same cycle; payloads stable while valid; leave to BRESP only after both handshakes.
REQ-038 BRESP: bready=1; on bvalid capture bresp into rsp_resp, rsp_rdata=0, -> RSP; bvalid arriving before BRESP is not sampled.
REQ-039 RADDR: arvalid held until arready, then RDATA with rready=1; on rvalid capture rdata/rresp -> RSP.
REQ-040 RSP: rsp_valid=1, rsp_rdata/rsp_resp stable until rsp_ready; then IDLE, cmd_ready=1 next cycle.
REQ-041 Zero-wait slave: write cmd at T, aw/w handshake T+1, bvalid T+2, rsp_valid T+3; read identical timing.
REQ-042 SLVERR/DECERR passed verbatim, no retry; no timeout; valid never deasserted without handshake.

Reset
REQ-043 Reset assertion, any state incl. mid-transaction: immediately state=IDLE, all valid/ready outputs 0, data/addr/resp regs 0, transaction abandoned; cmd_ready=1 from first edge after deassertion.

Verification
REQ-044 Write addr 0x10, data 0x1122334455667788, strb 0xFF, zero-wait slave -> aw/w at T+1, rsp_valid T+3, rsp_resp 0, rsp_rdata 0.
REQ-045 Read addr 0x20, slave returns 0xDEADBEEF with 1-cycle rvalid delay -> rsp_rdata 0xDEADBEEF, rsp_resp 0.
REQ-046 Write, wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held stable, bready only after both.
REQ-047 Read returning rresp=2'b10, rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_resp=2 stable, cmd_ready 0 throughout.
REQ-048 Reset asserted while awvalid=1 waiting -> awvalid 0 asynchronously; after release cmd_ready=1, next read completes normally.
